// File: rtl/addsub_arbiter_if.sv
// -----------------------------------------------------------------------------
// addsub_arbiter_if
// Bundle between R requesters and the shared add/subtract sequencer.
//   req     [R]     level request per requester
//   a_in    [R*N]   packed first operands, requester i at [i*N +: N]
//   b_in    [R*N]   packed second operands, same packing
//   sub_in  [R]     1 = a-b, 0 = a+b
//   gnt     [R]     one-hot pulse: that requester's operands were captured
//   busy            high while an operation executes
//   done            one-cycle pulse: s/ovf/done_id valid
//   done_id [IW]    requester index of the result on s
//   s       [N]     registered result
//   ovf             registered two's-complement overflow
// Modports: master = requester side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface addsub_arbiter_if #(
   parameter int N = 8,
   parameter int R = 4
);
   localparam int IW = $clog2(R);

   logic [R-1:0]   req;
   logic [R*N-1:0] a_in;
   logic [R*N-1:0] b_in;
   logic [R-1:0]   sub_in;
   logic [R-1:0]   gnt;
   logic           busy;
   logic           done;
   logic [IW-1:0]  done_id;
   logic [N-1:0]   s;
   logic           ovf;

   modport master (
      output req, a_in, b_in, sub_in,
      input  gnt, busy, done, done_id, s, ovf
   );

   modport slave (
      input  req, a_in, b_in, sub_in,
      output gnt, busy, done, done_id, s, ovf
   );
endinterface

// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
// Round-robin sequencer sharing one N-bit add/subtract datapath among R
// requesters. The winner's operands are latched, one add or subtract runs,
// and the registered sum/overflow come back tagged with the requester index.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    addsub_arbiter_if.slave (req/a_in/b_in/sub_in in; gnt/busy/done/
//          done_id/s/ovf out, all registered)
// Build option:
//   ADDSUB_SAT_EN  when defined, an overflowing result is clamped to the max
//                  positive / min negative value (sign taken from op_a);
//                  ovf is still reported. Undefined: wrapped result.
// -----------------------------------------------------------------------------
module addsub_arbiter #(
   parameter int N = 8,
   parameter int R = 4
) (
   input logic               clk,
   input logic               rst_n,
   addsub_arbiter_if.slave   bus
);
   localparam int IW = $clog2(R);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t         state, state_nxt;
   logic [IW-1:0]  ptr;
   logic [IW-1:0]  cur_id;
   logic [N-1:0]   op_a, op_b;
   logic           op_sub;

   logic           win_valid;
   logic [IW-1:0]  win_id;
   logic           capture;

   logic [N-1:0]   b_eff;
   logic [N:0]     full;
   logic           c_in_msb;
   logic           ovf_res;
   logic [N-1:0]   s_res;

   // Round-robin pick: scan downward so the last hit, i.e. the one closest
   // to ptr, wins.
   // NOTE: every combinational output gets a default before any branch, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      int idx;
      idx       = 0;
      win_valid = 1'b0;
      win_id    = '0;
      for (int k = R - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % R;
         if (bus.req[idx]) begin
            win_valid = 1'b1;
            win_id    = IW'(idx);
         end
      end
   end

   // Requests are only looked at outside EXEC.
   assign capture = (state != EXEC) && win_valid;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: state_nxt = win_valid ? EXEC : IDLE;
         EXEC:       state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Shared datapath: a - b is a + ~b + 1. Carry into the MSB is recovered
   // from the MSB sum bit, so overflow = carry-in(MSB) ^ carry-out(MSB).
   always_comb begin
      b_eff    = op_sub ? ~op_b : op_b;
      full     = {1'b0, op_a} + {1'b0, b_eff} + (N + 1)'(op_sub);
      c_in_msb = op_a[N-1] ^ b_eff[N-1] ^ full[N-1];
      ovf_res  = c_in_msb ^ full[N];
`ifdef ADDSUB_SAT_EN
      if (ovf_res)
         s_res = op_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      else
         s_res = full[N-1:0];
`else
      s_res = full[N-1:0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         cur_id      <= '0;
         op_a        <= '0;
         op_b        <= '0;
         op_sub      <= 1'b0;
         bus.gnt     <= '0;
         bus.done_id <= '0;
         bus.s       <= '0;
         bus.ovf     <= 1'b0;
      end else begin
         state   <= state_nxt;
         bus.gnt <= '0;
         if (capture) begin
            op_a    <= bus.a_in[int'(win_id)*N +: N];
            op_b    <= bus.b_in[int'(win_id)*N +: N];
            op_sub  <= bus.sub_in[win_id];
            cur_id  <= win_id;
            ptr     <= (win_id == IW'(R - 1)) ? '0 : win_id + 1'b1;
            bus.gnt <= {{(R-1){1'b0}}, 1'b1} << win_id;
         end
         if (state == EXEC) begin
            bus.s       <= s_res;
            bus.ovf     <= ovf_res;
            bus.done_id <= cur_id;
         end
      end
   end

   // Both decoded straight from the state register, so still registered.
   assign bus.busy = (state == EXEC);
   assign bus.done = (state == DONE);

endmodule
